// File: rtl/rvscc_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
package rvscc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH is a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC owner, credit-limited imem requests, response buffer and
// valid/ready hand-off to decode, with full flush on redirect.
module instr_fetch
  import rvscc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q, resp_pc_q, redir_tgt;
  logic [CW-1:0] outstanding_q, discard_q, out_nxt, fifo_count;
  logic [CW:0]   credit;
  logic          req_fire, rsp_ok, push, pop, fifo_full, fifo_empty;
  fetch_entry_t  wentry, head;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign pop       = id_valid && id_ready;

  // A same-cycle pop frees its slot at the edge, before any new response can land,
  // so it is credited immediately to sustain one fetch per cycle.
  assign credit         = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = rst_n && !redirect_valid && (credit < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_ok  = imem_rsp_valid && (outstanding_q != '0);
  assign push    = rsp_ok && (discard_q == '0) && !redirect_valid;
  assign out_nxt = outstanding_q + {{CW-1{1'b0}}, req_fire} - {{CW-1{1'b0}}, rsp_ok};
  assign wentry  = '{instr: imem_rsp_data, pc: resp_pc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= out_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc_q      <= redir_tgt;
        resp_pc_q <= redir_tgt;
        discard_q <= out_nxt;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        if (push)     resp_pc_q <= resp_pc_q + 32'd4;
        if (rsp_ok && discard_q != '0) discard_q <= discard_q - CW'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign id_valid    = !fifo_empty;
  assign id_instr    = id_valid ? head.instr        : '0;
  assign id_pc       = id_valid ? head.pc           : '0;
  assign id_pc_plus4 = id_valid ? head.pc + 32'd4   : '0;

  a_rsp_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> outstanding_q != '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch: two instances (RESET_PC 0 and
// FFFF_FFF8) share stimulus; each has an in-order memory model and a PC-stream scoreboard.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  int          lat_min = 1, lat_max = 1;
  bit          rdy_rand = 1'b0;
  int          n_chk = 0, n_pass = 0, n_hs = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [31:0] RP = (g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;

    logic        req_valid, req_ready, rsp_valid, id_valid;
    logic [31:0] req_addr, rsp_data, id_instr, id_pc, id_pc_plus4;
    mreq_t       q[$];
    logic        hs_req = 1'b0, hs_rsp = 1'b0;
    logic [31:0] hs_addr = '0;
    logic [31:0] exp_pc = RP;
    int          cyc = 0;

    instr_fetch #(.RESET_PC(RP), .FIFO_DEPTH(2)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (req_valid),
      .imem_req_ready (req_ready),
      .imem_req_addr  (req_addr),
      .imem_rsp_valid (rsp_valid),
      .imem_rsp_data  (rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
    );

    // Memory: in-order, per-request latency in [lat_min, lat_max]; word = ~addr.
    always @(negedge clk) begin
      cyc++;
      if (!rst_n) q.delete();
      else begin
        if (hs_rsp && q.size() > 0) void'(q.pop_front());
        if (hs_req) q.push_back('{addr: hs_addr, due: cyc + int'($urandom_range(lat_min, lat_max)) - 1});
      end
      req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      rsp_valid = rst_n && (q.size() > 0) && (q.size() > 0 ? q[0].due <= cyc : 1'b0);
      rsp_data  = rsp_valid ? ~q[0].addr : '0;
      #1;
      hs_req  = rst_n && req_valid && req_ready;
      hs_addr = req_addr;
      hs_rsp  = rsp_valid;
      // Reference stream: sequential PCs, restarted by reset or redirect.
      if (!rst_n) exp_pc = RP;
      else begin
        if (id_valid && id_ready) begin
          chk($sformatf("sb%0d_pc", g), id_pc, exp_pc);
          chk($sformatf("sb%0d_instr", g), id_instr, ~exp_pc);
          chk($sformatf("sb%0d_pc4", g), id_pc_plus4, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          if (g == 0) n_hs++;
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #2;
  endtask

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic wait_id(input string tag);
    int n = 0;
    while (!g_dut[0].id_valid && n < 30) begin step(); n++; end
    chk({tag, "_timeout"}, 32'(g_dut[0].id_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq;
    bit hold_ok;
    int hs0;
    id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    repeat (2) @(negedge clk); #2;
    chk("rst_req_valid", 32'(g_dut[0].req_valid), 0);
    chk("rst_id_valid",  32'(g_dut[0].id_valid), 0);
    chk("rst_id_instr",  g_dut[0].id_instr, 0);
    chk("rst_id_pc",     g_dut[0].id_pc, 0);
    chk("rst_id_pc4",    g_dut[0].id_pc_plus4, 0);
    chk("rst_req_valid1", 32'(g_dut[1].req_valid), 0);

    // 1-cycle memory streaming; instance 1 covers the 32-bit PC wrap
    @(negedge clk); rst_n = 1'b1; #2;
    chk("t1_addr0", g_dut[0].req_addr, 32'h0);
    chk("t1_rv0",   32'(g_dut[0].req_valid), 1);
    chk("t4_addr0", g_dut[1].req_addr, 32'hFFFF_FFF8);
    step();
    chk("t1_addr1", g_dut[0].req_addr, 32'h4);
    chk("t1_idv1",  32'(g_dut[0].id_valid), 0);
    chk("t4_addr1", g_dut[1].req_addr, 32'hFFFF_FFFC);
    step();
    chk("t1_addr2", g_dut[0].req_addr, 32'h8);
    chk("t1_pc2",   g_dut[0].id_pc, 32'h0);
    chk("t1_pc4_2", g_dut[0].id_pc_plus4, 32'h4);
    chk("t1_ins2",  g_dut[0].id_instr, 32'hFFFF_FFFF);
    chk("t4_addr2", g_dut[1].req_addr, 32'h0);
    chk("t4_pc2",   g_dut[1].id_pc, 32'hFFFF_FFF8);
    step();
    chk("t1_pc3",   g_dut[0].id_pc, 32'h4);
    chk("t4_pc3",   g_dut[1].id_pc, 32'hFFFF_FFFC);
    chk("t4_pc4_3", g_dut[1].id_pc_plus4, 32'h0);
    step();
    chk("t1_idv4",  32'(g_dut[0].id_valid), 1);
    chk("t1_pc4",   g_dut[0].id_pc, 32'h8);

    // Decode stalled: two requests fill the credits, head holds steady
    id_ready = 1'b0;
    reset_dut();
    nreq = 0; hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      if (g_dut[0].req_valid && g_dut[0].req_ready) nreq++;
      if (i >= 2 && !(g_dut[0].id_valid && g_dut[0].id_pc == 32'h0 && g_dut[0].id_instr == 32'hFFFF_FFFF))
        hold_ok = 1'b0;
    end
    chk("t2_nreq",  32'(nreq), 2);
    chk("t2_rv",    32'(g_dut[0].req_valid), 0);
    chk("t2_hold",  32'(hold_ok), 1);
    @(negedge clk); id_ready = 1'b1; #2;
    chk("t2_pc_rel", g_dut[0].id_pc, 32'h0);
    chk("t2_addr_rel", g_dut[0].req_addr, 32'h8);
    chk("t2_rv_rel", 32'(g_dut[0].req_valid), 1);
    step();
    chk("t2_pc_nxt", g_dut[0].id_pc, 32'h4);
    repeat (4) step();

    // Redirect with two requests outstanding (3-cycle memory)
    lat_min = 3; lat_max = 3;
    reset_dut();
    step();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; #2;
    chk("t3_rv_redir", 32'(g_dut[0].req_valid), 0);
    @(negedge clk); redirect_valid = 1'b0; #2;
    chk("t3_idv_c3", 32'(g_dut[0].id_valid), 0);
    chk("t3_rv_c3",  32'(g_dut[0].req_valid), 0);
    step();
    chk("t3_addr",   g_dut[0].req_addr, 32'h100);
    chk("t3_rv_c4",  32'(g_dut[0].req_valid), 1);
    chk("t3_idv_c4", 32'(g_dut[0].id_valid), 0);
    wait_id("t3");
    chk("t3_pc",  g_dut[0].id_pc, 32'h100);
    chk("t3_ins", g_dut[0].id_instr, ~32'h100);
    repeat (4) step();

    // Random latency, backpressure and redirects against the scoreboards
    lat_min = 1; lat_max = 5; rdy_rand = 1'b1;
    reset_dut();
    hs0 = n_hs;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
    end
    @(negedge clk); redirect_valid = 1'b0; id_ready = 1'b1; rdy_rand = 1'b0;
    repeat (20) step();
    chk("t5_progress", 32'(n_hs - hs0 > 500), 1);

    // Reset asserted mid-burst with two outstanding
    lat_min = 3; lat_max = 3;
    reset_dut();
    step();
    @(negedge clk); #3; rst_n = 1'b0; #1;
    chk("t6_rv",   32'(g_dut[0].req_valid), 0);
    chk("t6_idv",  32'(g_dut[0].id_valid), 0);
    chk("t6_pc",   g_dut[0].id_pc, 0);
    chk("t6_ins",  g_dut[0].id_instr, 0);
    chk("t6_pc4",  g_dut[0].id_pc_plus4, 0);
    chk("t6_rv1",  32'(g_dut[1].req_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #2;
    chk("t6_addr0", g_dut[0].req_addr, 32'h0);
    chk("t6_addr0_1", g_dut[1].req_addr, 32'hFFFF_FFF8);
    step();
    chk("t6_addr1", g_dut[0].req_addr, 32'h4);
    wait_id("t6");
    chk("t6_first_pc", g_dut[0].id_pc, 32'h0);
    chk("t6_first_ins", g_dut[0].id_instr, 32'hFFFF_FFFF);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
